// File: rtl/md_pad_pkg.sv
// Shared definitions for the Mega Drive pad responder: button indices,
// output pin bundle, mux selection and default timeout.
package md_pad_pkg;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_A     = 4;
  localparam int unsigned BTN_B     = 5;
  localparam int unsigned BTN_C     = 6;
  localparam int unsigned BTN_START = 7;
  localparam int unsigned BTN_X     = 8;
  localparam int unsigned BTN_Y     = 9;
  localparam int unsigned BTN_Z     = 10;
  localparam int unsigned BTN_MODE  = 11;
  localparam int unsigned NUM_BUTTONS = 12;

  // 1.5 ms at 50 MHz
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 75000;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic tl;
    logic tr;
  } pad_pins_t;

  // What D0-D3 carry for the current select level / phase
  typedef enum logic [2:0] {
    MUX_DPAD,
    MUX_AST,
    MUX_ID,
    MUX_XYZM,
    MUX_ALL1
  } pad_mux_t;

endpackage

// File: rtl/md_pad_responder_if.sv
// Pad port bundle: host side drives select/buttons/mode, pad side answers
// with the six active-low data pins and a debug phase index.
interface md_pad_responder_if;
  import md_pad_pkg::*;

  logic                   pad_sel;
  logic [NUM_BUTTONS-1:0] buttons;
  logic                   six_button_en;
  logic                   pad_up;
  logic                   pad_down;
  logic                   pad_left;
  logic                   pad_right;
  logic                   pad_tl;
  logic                   pad_tr;
  logic [1:0]             phase;

  modport master (
    output pad_sel, buttons, six_button_en,
    input  pad_up, pad_down, pad_left, pad_right, pad_tl, pad_tr, phase
  );

  modport slave (
    input  pad_sel, buttons, six_button_en,
    output pad_up, pad_down, pad_left, pad_right, pad_tl, pad_tr, phase
  );

endinterface

// File: rtl/md_pad_sel_sync.sv
// Select-line synchronizer followed by one edge-detect register.
// Everything resets high to match an idle (released) select line.
module md_pad_sel_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_sel,
  output logic o_sel,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sel};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sel  = r_sync[SYNC_STAGES-1];
  assign o_rise = o_sel & ~r_prev;
  assign o_fall = ~o_sel & r_prev;

endmodule

// File: rtl/md_pad_responder.sv
// Device-side Mega Drive joypad: answers the host select line with the
// 3-button or 6-button pin pattern, tracking phase and inactivity timeout.
module md_pad_responder
  import md_pad_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic               clock,
  input  logic               reset,
  md_pad_responder_if.slave  pad
);

  localparam int unsigned    TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic                   w_sel;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_expired;
  logic [1:0]             w_phase_nxt;
  pad_mux_t               w_mode;
  logic [3:0]             w_dir;
  pad_pins_t              w_pins;
  logic [NUM_BUTTONS-1:0] w_btn;

  logic [TW-1:0]          r_tmo;
  logic [1:0]             r_phase;
  pad_pins_t              r_pins;

  md_pad_sel_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sel_sync (
    .clock  (clock),
    .reset  (reset),
    .i_sel  (pad.pad_sel),
    .o_sel  (w_sel),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_btn     = pad.buttons;
  assign w_expired = (r_tmo == TMO_MAX);

  // A rise on the expiry cycle still sees r_tmo one short of the limit,
  // so it counts as a continuing sequence.
  always_comb begin
    w_phase_nxt = r_phase;
    if (w_rise)
      w_phase_nxt = w_expired ? 2'd1 : r_phase + 2'd1;
    else if (!w_fall && r_tmo == TMO_LAST)
      w_phase_nxt = '0;
  end

  // The mux uses the next phase so the pins switch level and pattern together.
  always_comb begin
    w_mode = MUX_DPAD;
    if (w_sel)
      w_mode = (pad.six_button_en && w_phase_nxt == 2'd3) ? MUX_XYZM : MUX_DPAD;
    else if (!pad.six_button_en || w_phase_nxt < 2'd2)
      w_mode = MUX_AST;
    else if (w_phase_nxt == 2'd2)
      w_mode = MUX_ID;
    else
      w_mode = MUX_ALL1;
  end

  always_comb begin
    w_dir = '1;
    case (w_mode)
      MUX_DPAD: w_dir = ~{w_btn[BTN_UP], w_btn[BTN_DOWN], w_btn[BTN_LEFT], w_btn[BTN_RIGHT]};
      MUX_AST:  w_dir = {~w_btn[BTN_UP], ~w_btn[BTN_DOWN], 2'b00};
      MUX_ID:   w_dir = '0;
      MUX_XYZM: w_dir = ~{w_btn[BTN_Z], w_btn[BTN_Y], w_btn[BTN_X], w_btn[BTN_MODE]};
      MUX_ALL1: w_dir = '1;
      default:  w_dir = '1;
    endcase
    w_pins.up    = w_dir[3];
    w_pins.down  = w_dir[2];
    w_pins.left  = w_dir[1];
    w_pins.right = w_dir[0];
    w_pins.tl    = w_sel ? ~w_btn[BTN_B] : ~w_btn[BTN_A];
    w_pins.tr    = w_sel ? ~w_btn[BTN_C] : ~w_btn[BTN_START];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tmo   <= '0;
      r_phase <= '0;
      r_pins  <= '1;
    end else begin
      if (w_rise || w_fall)
        r_tmo <= '0;
      else if (!w_expired)
        r_tmo <= r_tmo + TW'(1);
      r_phase <= w_phase_nxt;
      r_pins  <= w_pins;
    end
  end

  assign pad.pad_up    = r_pins.up;
  assign pad.pad_down  = r_pins.down;
  assign pad.pad_left  = r_pins.left;
  assign pad.pad_right = r_pins.right;
  assign pad.pad_tl    = r_pins.tl;
  assign pad.pad_tr    = r_pins.tr;
  assign pad.phase     = r_phase;

endmodule
